vx_mp_ram: RTL and testbench
============================

VX_MP_RAM -- requirements
Module: VX_mp_ram

Interface
REQ-001 SHALL have parameter DATAW, default 32, word width in bits.
REQ-002 SHALL have parameter SIZE, default 16, number of words; need not be a power of two.
REQ-003 SHALL have parameter WRENW, default 4, number of write-enable lanes; DATAW % WRENW == 0, lane width LW = DATAW/WRENW.
REQ-004 SHALL have parameter NUM_RPORTS, default 2, number of independent read ports (>=1).
REQ-005 SHALL have parameter OUT_REG, default 0; 0 = combinational read, 1 = registered read.
REQ-006 SHALL have parameter RDW_MODE, default 0; 0 = read-during-write returns old data, 1 = returns new data.
REQ-007 SHALL have parameter INIT_VALUE, default 0, DATAW-bit value written by the clear engine.
REQ-008 SHALL have parameter ADDRW, default $clog2(SIZE), address width.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 reset_n  in  1  reset, asynchronous, active-low.
REQ-011 clear  in  1  single-cycle request to re-initialise all words to INIT_VALUE.
REQ-012 ready  out  1  high when the clear engine is idle and ports are accepted.
REQ-013 wren  in  WRENW  per-lane write enable.
REQ-014 waddr  in  ADDRW  write address.
REQ-015 wdata  in  DATAW  write data.
REQ-016 ren  in  NUM_RPORTS  per-port read enable.
REQ-017 raddr  in  NUM_RPORTS x ADDRW  per-port read address.
REQ-018 rdata  out  NUM_RPORTS x DATAW  per-port read data.
REQ-019 rvalid  out  NUM_RPORTS  per-port read-data qualifier.

Function
REQ-020 Clear FSM SHALL have states INIT and READY; INIT writes INIT_VALUE to address cnt each cycle, cnt 0..SIZE-1.
REQ-021 INIT with cnt==SIZE-1 SHALL go to READY next cycle; ready asserts exactly SIZE cycles after reset_n release.
REQ-022 clear in READY SHALL enter INIT with cnt=0 next cycle; clear in INIT SHALL restart cnt at 0.
REQ-023 While ready==0, wren and ren SHALL be ignored; rvalid SHALL be 0.
REQ-024 clear and nonzero wren in the same READY cycle: write SHALL be dropped, clear wins.
REQ-025 Write: for each lane i with wren[i]=1, bits [i*LW +: LW] of word waddr SHALL update at the clock edge; other lanes unchanged.
REQ-026 waddr >= SIZE SHALL drop the write; raddr >= SIZE SHALL return rdata 0.
REQ-027 OUT_REG=0: rdata[p] = word raddr[p] combinationally; rvalid[p] = ren[p] & ready, same cycle.
REQ-028 OUT_REG=1: rdata[p] SHALL register on cycle with ren[p]&ready, rvalid[p] one cycle later; rdata[p] holds when not enabled.
REQ-029 Read-during-write (raddr[p]==waddr, write accepted): RDW_MODE=0 SHALL return pre-write word; RDW_MODE=1 SHALL return wdata on enabled lanes, stored data on others.
REQ-030 All read ports SHALL operate independently; identical addresses on several ports SHALL return identical data.

Reset
REQ-031 reset_n low SHALL asynchronously force state INIT, cnt 0, ready 0, rvalid 0, registered rdata 0.
REQ-032 Storage SHALL NOT be reset directly; only the clear engine initialises it.
REQ-033 reset_n asserted mid-INIT or with a read in flight SHALL discard progress and pending rvalid; INIT restarts from 0 on release.

Structure
REQ-034 Package VX_ram_pkg SHALL hold the clear-FSM state enum and RDW_MODE constants (RDW_OLD=0, RDW_NEW=1).
REQ-035 Clear FSM and counter SHALL be sub-module VX_ram_init_ctrl (outputs ready, init write enable, init address).
REQ-036 Storage SHALL be one array written by a single muxed write port (init vs user) and read by NUM_RPORTS read muxes.

Verification (DATAW=32, SIZE=16, WRENW=4, NUM_RPORTS=2)
REQ-037 Release reset_n, INIT_VALUE=32'hDEADBEEF -> ready rises at cycle 16; read all 16 addresses -> each returns 32'hDEADBEEF.
REQ-038 Write addr 3 data 32'h11223344 wren=4'b0101 over INIT 0 -> read addr 3 returns 32'h00220044.
REQ-039 RDW_MODE=1, OUT_REG=1, addr 5 holds 0, write 32'hAABBCCDD wren=4'b1111 while port0 reads 5 -> next cycle rvalid[0]=1, rdata[0]=32'hAABBCCDD; RDW_MODE=0 -> 0.
REQ-040 clear asserted with write to addr 2 -> write dropped, ready low 16 cycles, addr 2 returns INIT_VALUE, ren ignored meanwhile.
REQ-041 SIZE=12, write addr 13 and read port1 addr 14 -> no word changes, rdata[1]=0.
REQ-042 reset_n pulsed low at INIT cnt=7 -> ready 0 and rvalid 0 immediately, ready rises 16 cycles after release.

Source files
------------

// File: rtl/vx_ram_pkg.sv
// Shared types and constants for the multi-port RAM and its clear engine.
package vx_ram_pkg;

   // Clear-engine states: INIT sweeps the array, READY accepts user traffic
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } init_state_e;

   // Read-during-write behaviour selectors
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

endpackage

// File: rtl/vx_ram_init_ctrl.sv
// Clear engine: walks every address once after reset or a clear request,
// handing the write port to the initialiser until the sweep completes.
module vx_ram_init_ctrl
   import vx_ram_pkg::*;
#(
   parameter int SIZE  = 16,
   parameter int ADDRW = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   output logic             ready,
   output logic             init_we,
   output logic [ADDRW-1:0] init_addr
);

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

   init_state_e      state;
   init_state_e      state_next;
   logic [ADDRW-1:0] cnt;
   logic [ADDRW-1:0] cnt_next;

   // State and sweep counter; reset drops any sweep in progress and restarts at 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next state: a clear always restarts the sweep, even one already running
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         INIT: begin
            if (clear) begin
               cnt_next = '0;
            end else if (cnt == LAST_ADDR) begin
               state_next = READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         READY: begin
            cnt_next = '0;
            if (clear) begin
               state_next = INIT;
            end
         end
         default: begin
            state_next = INIT;
            cnt_next   = '0;
         end
      endcase
   end

   assign ready     = (state == READY);
   assign init_we   = (state == INIT);
   assign init_addr = cnt;

endmodule

// File: rtl/vx_mp_ram.sv
// Multi-port RAM: one lane-masked write port shared with the clear engine,
// NUM_RPORTS independent read ports, optional output register and
// selectable read-during-write behaviour.
module vx_mp_ram
   import vx_ram_pkg::*;
#(
   parameter int               DATAW      = 32,
   parameter int               SIZE       = 16,
   parameter int               WRENW      = 4,
   parameter int               NUM_RPORTS = 2,
   parameter int               OUT_REG    = 0,
   parameter int               RDW_MODE   = 0,
   parameter logic [DATAW-1:0] INIT_VALUE = '0,
   parameter int               ADDRW      = $clog2(SIZE)
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 clear,
   output logic                                 ready,
   input  logic [WRENW-1:0]                     wren,
   input  logic [ADDRW-1:0]                     waddr,
   input  logic [DATAW-1:0]                     wdata,
   input  logic [NUM_RPORTS-1:0]                ren,
   input  logic [NUM_RPORTS-1:0][ADDRW-1:0]     raddr,
   output logic [NUM_RPORTS-1:0][DATAW-1:0]     rdata,
   output logic [NUM_RPORTS-1:0]                rvalid
);

   localparam int LW = DATAW / WRENW;

   logic                                init_we;
   logic [ADDRW-1:0]                    init_addr;
   logic                                user_accept;
   logic [WRENW-1:0]                    mem_lanes;
   logic [ADDRW-1:0]                    mem_addr;
   logic [DATAW-1:0]                    mem_data;
   logic [NUM_RPORTS-1:0]               rd_fire;
   logic [NUM_RPORTS-1:0][DATAW-1:0]    rd_word;
   logic [DATAW-1:0]                    mem [SIZE];

   vx_ram_init_ctrl #(
      .SIZE  (SIZE),
      .ADDRW (ADDRW)
   ) u_init_ctrl (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .ready     (ready),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   // A user write lands only when idle, not being cleared, and in range
   assign user_accept = ready && !clear && (|wren) && (32'(waddr) < SIZE);
   assign rd_fire     = ren & {NUM_RPORTS{ready}};

   // Single write port: the clear engine owns it while sweeping
   always_comb begin
      mem_lanes = user_accept ? wren : '0;
      mem_addr  = waddr;
      mem_data  = wdata;
      if (init_we) begin
         mem_lanes = '1;
         mem_addr  = init_addr;
         mem_data  = INIT_VALUE;
      end
   end

   // Storage itself is never reset; contents come only from the clear engine
   always_ff @(posedge clk) begin
      for (int i = 0; i < WRENW; i++) begin
         if (mem_lanes[i]) begin
            mem[mem_addr][i*LW +: LW] <= mem_data[i*LW +: LW];
         end
      end
   end

   // Read muxes: out-of-range addresses read as zero; in new-data mode a
   // colliding accepted write is forwarded lane by lane
   always_comb begin
      rd_word = '0;
      for (int p = 0; p < NUM_RPORTS; p++) begin
         if (32'(raddr[p]) < SIZE) begin
            rd_word[p] = mem[raddr[p]];
            if ((RDW_MODE == RDW_NEW) && user_accept && (raddr[p] == waddr)) begin
               for (int i = 0; i < WRENW; i++) begin
                  if (wren[i]) begin
                     rd_word[p][i*LW +: LW] = wdata[i*LW +: LW];
                  end
               end
            end
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_RPORTS-1:0][DATAW-1:0] rdata_q;
      logic [NUM_RPORTS-1:0]            rvalid_q;

      // Registered read: data captured on an accepted read and held otherwise
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= '0;
         end else begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
               if (rd_fire[p]) begin
                  rdata_q[p] <= rd_word[p];
               end
            end
            rvalid_q <= rd_fire;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end else begin : g_out_comb
      assign rdata  = rd_word;
      assign rvalid = rd_fire;
   end

endmodule

// File: tb/tb_vx_mp_ram.sv
// Scoreboard bench for vx_mp_ram: two registered 16-word instances sharing
// stimulus (new-data and old-data read-during-write) and one combinational
// 12-word instance with out-of-range addresses.
module tb_vx_mp_ram;

   logic clk;

   logic              a_reset_n, a_clear;
   logic [3:0]        a_wren, a_waddr;
   logic [31:0]       a_wdata;
   logic [1:0]        a_ren;
   logic [1:0][3:0]   a_raddr;
   logic              a_ready, c_ready;
   logic [1:0][31:0]  a_rdata, c_rdata;
   logic [1:0]        a_rvalid, c_rvalid;

   logic              b_reset_n, b_clear;
   logic [3:0]        b_wren, b_waddr;
   logic [31:0]       b_wdata;
   logic [1:0]        b_ren;
   logic [1:0][3:0]   b_raddr;
   logic              b_ready;
   logic [1:0][31:0]  b_rdata;
   logic [1:0]        b_rvalid;

   logic [31:0] modelA [16];
   logic [31:0] modelC [16];
   logic [31:0] modelB [12];

   // queue index: 0/1 = dut_a ports, 2/3 = dut_c ports, 4/5 = dut_b ports
   logic [31:0] expQ [6][$];

   int nAsserts = 0;
   int nFails   = 0;

   logic [5:0]  monValid;
   logic [31:0] monData [6];

   vx_mp_ram #(.DATAW(32), .SIZE(16), .WRENW(4), .NUM_RPORTS(2), .OUT_REG(1),
               .RDW_MODE(1), .INIT_VALUE(32'hDEADBEEF)) dut_a (
      .clk(clk), .reset_n(a_reset_n), .clear(a_clear), .ready(a_ready),
      .wren(a_wren), .waddr(a_waddr), .wdata(a_wdata),
      .ren(a_ren), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid));

   vx_mp_ram #(.DATAW(32), .SIZE(16), .WRENW(4), .NUM_RPORTS(2), .OUT_REG(1),
               .RDW_MODE(0), .INIT_VALUE(32'h0)) dut_c (
      .clk(clk), .reset_n(a_reset_n), .clear(a_clear), .ready(c_ready),
      .wren(a_wren), .waddr(a_waddr), .wdata(a_wdata),
      .ren(a_ren), .raddr(a_raddr), .rdata(c_rdata), .rvalid(c_rvalid));

   vx_mp_ram #(.DATAW(32), .SIZE(12), .WRENW(4), .NUM_RPORTS(2), .OUT_REG(0),
               .RDW_MODE(0), .INIT_VALUE(32'h0)) dut_b (
      .clk(clk), .reset_n(b_reset_n), .clear(b_clear), .ready(b_ready),
      .wren(b_wren), .waddr(b_waddr), .wdata(b_wdata),
      .ren(b_ren), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid));

   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // hard time limit so a stuck design still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] lanes);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (lanes[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // count ticks until ready (bounded) and compare with the expected latency
   task automatic waitReady(input string tag, input bit isB, input int expected);
      int cnt = 0;
      while (!(isB ? b_ready : a_ready) && cnt < 64) begin
         tick();
         cnt++;
      end
      a_ren = '0;
      b_ren = '0;
      checkOutput(tag, 32'(cnt), 32'(expected));
   endtask

   // one cycle of stimulus on the 16-word pair, with expectations and model update
   task automatic applyStimulus(input logic clr, input logic [3:0] wen, input logic [3:0] wa,
                                input logic [31:0] wd, input logic [1:0] re,
                                input logic [3:0] ra0, input logic [3:0] ra1);
      logic accept;
      logic [3:0] ra;
      accept = a_ready && !clr && (wen != 4'b0);
      a_clear = clr; a_wren = wen; a_waddr = wa; a_wdata = wd;
      a_ren = re; a_raddr[0] = ra0; a_raddr[1] = ra1;
      for (int p = 0; p < 2; p++) begin
         if (re[p] && a_ready) begin
            ra = (p == 0) ? ra0 : ra1;
            if (accept && ra == wa) expQ[p].push_back(merge(modelA[ra], wd, wen));
            else                    expQ[p].push_back(modelA[ra]);
            expQ[2+p].push_back(modelC[ra]);
         end
      end
      if (clr && a_ready) begin
         for (int i = 0; i < 16; i++) begin
            modelA[i] = 32'hDEADBEEF;
            modelC[i] = 32'h0;
         end
      end else if (accept) begin
         modelA[wa] = merge(modelA[wa], wd, wen);
         modelC[wa] = merge(modelC[wa], wd, wen);
      end
      tick();
      a_clear = 1'b0; a_wren = '0; a_ren = '0;
   endtask

   // one cycle of stimulus on the 12-word combinational instance
   task automatic applyB(input logic [3:0] wen, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
      logic accept;
      logic [3:0] ra;
      accept = b_ready && (wen != 4'b0) && (wa < 4'd12);
      b_wren = wen; b_waddr = wa; b_wdata = wd;
      b_ren = re; b_raddr[0] = ra0; b_raddr[1] = ra1;
      for (int p = 0; p < 2; p++) begin
         if (re[p] && b_ready) begin
            ra = (p == 0) ? ra0 : ra1;
            expQ[4+p].push_back((ra < 4'd12) ? modelB[ra] : 32'h0);
         end
      end
      if (accept) modelB[wa] = merge(modelB[wa], wd, wen);
      tick();
      b_wren = '0; b_ren = '0;
   endtask

   // scoreboard: every rvalid pops and compares the oldest expectation for that port
   always @(negedge clk) begin
      monValid = {b_rvalid, c_rvalid, a_rvalid};
      monData[0] = a_rdata[0]; monData[1] = a_rdata[1];
      monData[2] = c_rdata[0]; monData[3] = c_rdata[1];
      monData[4] = b_rdata[0]; monData[5] = b_rdata[1];
      for (int k = 0; k < 6; k++) begin
         if (monValid[k]) begin
            if (expQ[k].size() == 0)
               checkOutput($sformatf("rvalid_unexpected_q%0d", k), 32'(monValid[k]), 32'h0);
            else
               checkOutput($sformatf("rdata_q%0d", k), monData[k], expQ[k].pop_front());
         end
      end
   end

   initial begin
      a_reset_n = 1'b0; a_clear = 1'b0; a_wren = '0; a_waddr = '0; a_wdata = '0;
      a_ren = '0; a_raddr = '0;
      b_reset_n = 1'b0; b_clear = 1'b0; b_wren = '0; b_waddr = '0; b_wdata = '0;
      b_ren = '0; b_raddr = '0;
      for (int i = 0; i < 16; i++) begin
         modelA[i] = 32'hDEADBEEF;
         modelC[i] = 32'h0;
      end
      for (int i = 0; i < 12; i++) modelB[i] = 32'h0;

      // reset state
      #1;
      checkOutput("reset_ready_a", 32'(a_ready), 32'h0);
      checkOutput("reset_rvalid_a", 32'(a_rvalid), 32'h0);
      checkOutput("reset_rvalid_c", 32'(c_rvalid), 32'h0);
      checkOutput("reset_rdata_a0", a_rdata[0], 32'h0);
      checkOutput("reset_rdata_c1", c_rdata[1], 32'h0);
      tick();
      tick();

      // release and wait out the initial sweep, reads requested meanwhile are ignored
      a_reset_n = 1'b1;
      a_ren = 2'b11;
      waitReady("init_latency_a", 1'b0, 16);
      checkOutput("init_ready_c", 32'(c_ready), 32'h1);

      // every word holds the init value; port1 walks the other direction
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b0, 4'b0, 4'd0, 32'h0, 2'b11, 4'(i), 4'(15 - i));

      // lane-masked write then read back
      applyStimulus(1'b0, 4'b0101, 4'd3, 32'h11223344, 2'b00, 4'd0, 4'd0);
      applyStimulus(1'b0, 4'b0, 4'd0, 32'h0, 2'b01, 4'd3, 4'd0);

      // read-during-write, full lanes then partial lanes on both ports
      applyStimulus(1'b0, 4'b1111, 4'd5, 32'hAABBCCDD, 2'b01, 4'd5, 4'd0);
      applyStimulus(1'b0, 4'b0011, 4'd5, 32'h01020304, 2'b11, 4'd5, 4'd5);
      applyStimulus(1'b0, 4'b0, 4'd0, 32'h0, 2'b11, 4'd5, 4'd3);

      // clear beats a simultaneous write; reads blocked during the sweep
      applyStimulus(1'b1, 4'b1111, 4'd2, 32'h12345678, 2'b00, 4'd0, 4'd0);
      checkOutput("clear_ready_low", 32'(a_ready), 32'h0);
      a_ren = 2'b11; a_raddr[0] = 4'd2; a_raddr[1] = 4'd5;
      waitReady("clear_latency", 1'b0, 16);
      applyStimulus(1'b0, 4'b0, 4'd0, 32'h0, 2'b11, 4'd2, 4'd5);

      // reset partway through a sweep restarts it from address 0
      applyStimulus(1'b1, 4'b0, 4'd0, 32'h0, 2'b00, 4'd0, 4'd0);
      for (int i = 0; i < 7; i++) tick();
      a_reset_n = 1'b0;
      #1;
      checkOutput("midinit_reset_ready", 32'(a_ready), 32'h0);
      checkOutput("midinit_reset_rvalid", 32'(a_rvalid), 32'h0);
      tick();
      a_reset_n = 1'b1;
      waitReady("midinit_restart", 1'b0, 16);

      // reset with a registered read in flight discards it
      applyStimulus(1'b0, 4'b0, 4'd0, 32'h0, 2'b01, 4'd3, 4'd0);
      checkOutput("inflight_rvalid_before", 32'(a_rvalid), 32'h1);
      a_reset_n = 1'b0;
      #1;
      checkOutput("inflight_rvalid_after", 32'(a_rvalid), 32'h0);
      checkOutput("inflight_rdata_after", a_rdata[0], 32'h0);
      expQ[0].delete();
      expQ[2].delete();
      tick();
      a_reset_n = 1'b1;
      waitReady("inflight_restart", 1'b0, 16);
      applyStimulus(1'b0, 4'b0, 4'd0, 32'h0, 2'b11, 4'd3, 4'd5);

      // 12-word combinational instance
      b_reset_n = 1'b1;
      waitReady("init_latency_b", 1'b1, 12);
      applyB(4'b0101, 4'd3, 32'h11223344, 2'b00, 4'd0, 4'd0);
      applyB(4'b0, 4'd0, 32'h0, 2'b01, 4'd3, 4'd0);
      applyB(4'b1111, 4'd13, 32'hFFFFFFFF, 2'b10, 4'd0, 4'd14);
      for (int i = 0; i < 12; i++)
         applyB(4'b0, 4'd0, 32'h0, 2'b11, 4'(i), 4'(i));
      applyB(4'b1111, 4'd7, 32'hCAFEF00D, 2'b01, 4'd7, 4'd0);
      applyB(4'b0, 4'd0, 32'h0, 2'b11, 4'd7, 4'd15);

      // every expectation must have been consumed
      tick();
      tick();
      for (int k = 0; k < 6; k++)
         checkOutput($sformatf("drain_q%0d", k), 32'(expQ[k].size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
